// File: rtl/fir_mac_serial.sv
// Time-multiplexed FIR: one signed multiplier and one accumulator walk the taps per sample,
// then the scaled, saturated result is registered with a one-cycle out_valid pulse.
module fir_mac_serial #(
    parameter int WIDTH_DATA = 8,
    parameter int WIDTH_COEF = 8,
    parameter int TAPS       = 8,
    parameter int SHIFT      = 0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic signed [WIDTH_DATA-1:0]  in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          coef_we,
    input  logic [$clog2(TAPS)-1:0]       coef_addr,
    input  logic signed [WIDTH_COEF-1:0]  coef_data,
    output logic                          busy,
    output logic signed [WIDTH_DATA-1:0]  out_data,
    output logic                          out_valid
);

    localparam int AW         = $clog2(TAPS);
    localparam int WIDTH_PROD = WIDTH_DATA + WIDTH_COEF;
    localparam int WIDTH_ACC  = WIDTH_PROD + AW;

    localparam logic [AW:0]   TAPS_C   = (AW + 1)'(TAPS);
    localparam logic [AW-1:0] LAST_IDX = AW'(TAPS - 1);

    localparam logic signed [WIDTH_ACC-1:0] SAT_MAX =
        {{(WIDTH_ACC - WIDTH_DATA + 1){1'b0}}, {(WIDTH_DATA - 1){1'b1}}};
    localparam logic signed [WIDTH_ACC-1:0] SAT_MIN =
        {{(WIDTH_ACC - WIDTH_DATA + 1){1'b1}}, {(WIDTH_DATA - 1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        DONE
    } state_e;

    state_e                        state_q, state_d;
    logic [AW-1:0]                 idx_q, idx_d;
    logic signed [WIDTH_ACC-1:0]   acc_q, acc_d;
    logic signed [WIDTH_DATA-1:0]  out_data_q, out_data_d;
    logic                          out_valid_q, out_valid_d;

    logic signed [WIDTH_DATA-1:0]  x_q [TAPS];
    logic signed [WIDTH_COEF-1:0]  c_q [TAPS];

    logic                          accept;
    logic                          coef_wr;
    logic signed [WIDTH_PROD-1:0]  prod;
    logic signed [WIDTH_ACC-1:0]   shifted;
    logic signed [WIDTH_DATA-1:0]  sat;

    // Datapath helpers: handshake qualifiers, the shared product and output scaling.
    always_comb begin
        accept  = (state_q == IDLE) && in_valid;
        coef_wr = (state_q == IDLE) && coef_we && ({1'b0, coef_addr} < TAPS_C);
        prod    = WIDTH_PROD'(x_q[idx_q]) * WIDTH_PROD'(c_q[idx_q]);
        shifted = acc_q >>> SHIFT;
        if (shifted > SAT_MAX) begin
            sat = SAT_MAX[WIDTH_DATA-1:0];
        end else if (shifted < SAT_MIN) begin
            sat = SAT_MIN[WIDTH_DATA-1:0];
        end else begin
            sat = shifted[WIDTH_DATA-1:0];
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        acc_d       = acc_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = MAC;
                    acc_d   = '0;
                    idx_d   = '0;
                end
            end
            MAC: begin
                acc_d = acc_q + WIDTH_ACC'(prod);
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + AW'(1);
                end
            end
            DONE: begin
                out_data_d  = sat;
                out_valid_d = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            acc_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            acc_q       <= acc_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    // A write and an accept on the same edge both land, so the new sample sees the new coefficient.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < TAPS; k++) begin
                x_q[k] <= '0;
                c_q[k] <= '0;
            end
        end else begin
            if (accept) begin
                for (int k = TAPS - 1; k > 0; k--) begin
                    x_q[k] <= x_q[k-1];
                end
                x_q[0] <= in_data;
            end
            if (coef_wr) begin
                c_q[coef_addr] <= coef_data;
            end
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_fir_mac_serial.sv
// Testbench for fir_mac_serial: randomized and directed samples checked against a
// sum-of-products reference model; instances cover SHIFT=0, SHIFT=7 and TAPS=6.
module tb_fir_mac_serial;

    logic              clk;
    logic              reset;
    logic signed [7:0] in_data;
    logic              in_valid;
    logic              coef_we;
    logic [2:0]        coef_addr;
    logic signed [7:0] coef_data;
    logic              in_ready, busy, out_valid;
    logic signed [7:0] out_data;
    logic              in_ready7, busy7, out_valid7;
    logic signed [7:0] out_data7;

    logic signed [7:0] in_data6;
    logic              in_valid6, coef_we6;
    logic [2:0]        coef_addr6;
    logic signed [7:0] coef_data6;
    logic              in_ready6, busy6, out_valid6;
    logic signed [7:0] out_data6;

    int n_cmp = 0;
    int n_err = 0;

    int mc [8];
    int mx [8];
    int mc6 [6];
    int mx6 [6];

    fir_mac_serial #(.WIDTH_DATA(8), .WIDTH_COEF(8), .TAPS(8), .SHIFT(0)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data), .busy(busy),
        .out_data(out_data), .out_valid(out_valid)
    );

    fir_mac_serial #(.WIDTH_DATA(8), .WIDTH_COEF(8), .TAPS(8), .SHIFT(7)) dut_s7 (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready7),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data), .busy(busy7),
        .out_data(out_data7), .out_valid(out_valid7)
    );

    fir_mac_serial #(.WIDTH_DATA(8), .WIDTH_COEF(8), .TAPS(6), .SHIFT(1)) dut6 (
        .clk(clk), .reset(reset), .in_data(in_data6), .in_valid(in_valid6), .in_ready(in_ready6),
        .coef_we(coef_we6), .coef_addr(coef_addr6), .coef_data(coef_data6), .busy(busy6),
        .out_data(out_data6), .out_valid(out_valid6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // y = sum c[k]*x[k], arithmetic shift, clamp to the 8-bit signed range.
    function automatic int clamp8(longint v);
        if (v > 127) return 127;
        if (v < -128) return -128;
        return int'(v);
    endfunction

    function automatic int model_y(int shift);
        longint acc = 0;
        for (int k = 0; k < 8; k++) acc += longint'(mc[k]) * longint'(mx[k]);
        return clamp8(acc >>> shift);
    endfunction

    function automatic int model6_y(int shift);
        longint acc = 0;
        for (int k = 0; k < 6; k++) acc += longint'(mc6[k]) * longint'(mx6[k]);
        return clamp8(acc >>> shift);
    endfunction

    task automatic model_push(input int d);
        for (int k = 7; k > 0; k--) mx[k] = mx[k-1];
        mx[0] = d;
    endtask

    task automatic model_clear();
        for (int k = 0; k < 8; k++) begin mc[k] = 0; mx[k] = 0; end
        for (int k = 0; k < 6; k++) begin mc6[k] = 0; mx6[k] = 0; end
    endtask

    function automatic int rand8();
        return int'($urandom_range(255)) - 128;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        in_valid = 1'b0; coef_we = 1'b0; in_valid6 = 1'b0; coef_we6 = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        model_clear();
    endtask

    task automatic write_coef(input int a, input int d);
        @(negedge clk);
        coef_we = 1'b1; coef_addr = 3'(a); coef_data = 8'(d);
        @(negedge clk);
        coef_we = 1'b0;
        if (a < 8) mc[a] = d;
    endtask

    // mode 0: plain sample; 1: coefficient write on the accept edge; 2: write held while busy.
    task automatic run_sample(input int d, input int mode, input int wa, input int wd,
                              output logic signed [7:0] y, output logic signed [7:0] y7,
                              output int lat, output bit tmo);
        int budget;
        tmo = 1'b0; lat = 0; budget = 0;
        @(negedge clk);
        in_data = 8'(d); in_valid = 1'b1;
        if (mode == 1) begin coef_we = 1'b1; coef_addr = 3'(wa); coef_data = 8'(wd); end
        while (in_ready !== 1'b1 && budget < 40) begin @(negedge clk); budget++; end
        if (in_ready !== 1'b1) begin
            tmo = 1'b1; in_valid = 1'b0; coef_we = 1'b0; y = 'x; y7 = 'x;
            return;
        end
        if (mode == 1) mc[wa] = wd;
        model_push(d);
        @(negedge clk);
        in_valid = 1'b0; coef_we = 1'b0;
        while (out_valid !== 1'b1 && lat < 40) begin
            if (mode == 2) begin coef_we = (lat < 6); coef_addr = 3'(wa); coef_data = 8'(wd); end
            @(negedge clk); lat++;
        end
        coef_we = 1'b0;
        tmo = (out_valid !== 1'b1);
        y = out_data; y7 = out_data7;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        #1;
        n_cmp++; if (out_data !== 8'sd0) begin n_err++; $display("[TB] FAIL reset_out_data: got %0d want 0", out_data); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("[TB] FAIL reset_in_ready: got %b want 1", in_ready); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    endtask

    task automatic test_impulse();
        logic signed [7:0] y, y7, e;
        int lat; bit tmo;
        do_reset();
        for (int k = 0; k < 8; k++) write_coef(k, 1);
        for (int i = 0; i < 9; i++) begin
            run_sample((i == 0) ? 10 : 0, 0, 0, 0, y, y7, lat, tmo);
            e = 8'(model_y(0));
            n_cmp++;
            if (tmo || y !== e) begin n_err++; $display("[TB] FAIL impulse[%0d]: got %0d want %0d", i, y, e); end
            e = 8'(model_y(7));
            n_cmp++;
            if (tmo || y7 !== e) begin n_err++; $display("[TB] FAIL impulse_s7[%0d]: got %0d want %0d", i, y7, e); end
        end
    endtask

    task automatic test_coef_order();
        logic signed [7:0] y, y7, e;
        int lat; bit tmo;
        do_reset();
        for (int k = 0; k < 8; k++) write_coef(k, k + 1);
        for (int i = 0; i < 3; i++) begin
            run_sample((i == 0) ? 1 : 0, 0, 0, 0, y, y7, lat, tmo);
            e = 8'(model_y(0));
            n_cmp++;
            if (tmo || y !== e) begin n_err++; $display("[TB] FAIL coef_order[%0d]: got %0d want %0d", i, y, e); end
            n_cmp++;
            if (lat != 9) begin n_err++; $display("[TB] FAIL latency[%0d]: got %0d want 9", i, lat); end
        end
    endtask

    task automatic test_saturation();
        logic signed [7:0] y, y7, e, e7;
        int lat; bit tmo;
        do_reset();
        for (int k = 0; k < 8; k++) write_coef(k, 127);
        for (int i = 0; i < 16; i++) begin
            run_sample((i < 8) ? 127 : -128, 0, 0, 0, y, y7, lat, tmo);
            e = 8'(model_y(0)); e7 = 8'(model_y(7));
            n_cmp++;
            if (tmo || y !== e) begin n_err++; $display("[TB] FAIL saturate[%0d]: got %0d want %0d", i, y, e); end
            n_cmp++;
            if (tmo || y7 !== e7) begin n_err++; $display("[TB] FAIL saturate_s7[%0d]: got %0d want %0d", i, y7, e7); end
        end
    endtask

    task automatic test_coef_write();
        logic signed [7:0] y, y7, e;
        int lat, v; bit tmo;
        do_reset();
        for (int k = 0; k < 8; k++) begin
            v = rand8();
            if (k == 0 && (v == 5 || v == 0)) v = 6;
            write_coef(k, v);
        end
        run_sample(77, 2, 0, 5, y, y7, lat, tmo);
        e = 8'(model_y(0));
        n_cmp++;
        if (tmo || y !== e) begin n_err++; $display("[TB] FAIL write_while_busy: got %0d want %0d", y, e); end
        write_coef(0, 5);
        run_sample(-90, 0, 0, 0, y, y7, lat, tmo);
        e = 8'(model_y(0));
        n_cmp++;
        if (tmo || y !== e) begin n_err++; $display("[TB] FAIL write_in_idle: got %0d want %0d", y, e); end
        run_sample(60, 1, 0, -7, y, y7, lat, tmo);
        e = 8'(model_y(0));
        n_cmp++;
        if (tmo || y !== e) begin n_err++; $display("[TB] FAIL write_with_accept: got %0d want %0d", y, e); end
    endtask

    task automatic test_random();
        logic signed [7:0] y, y7, e, e7;
        int lat; bit tmo;
        do_reset();
        for (int k = 0; k < 8; k++) write_coef(k, rand8());
        for (int i = 0; i < 12; i++) begin
            run_sample(rand8(), 0, 0, 0, y, y7, lat, tmo);
            e = 8'(model_y(0)); e7 = 8'(model_y(7));
            n_cmp++;
            if (tmo || y !== e) begin n_err++; $display("[TB] FAIL random[%0d]: got %0d want %0d", i, y, e); end
            n_cmp++;
            if (tmo || y7 !== e7) begin n_err++; $display("[TB] FAIL random_s7[%0d]: got %0d want %0d", i, y7, e7); end
        end
    endtask

    task automatic test_back_to_back();
        logic signed [7:0] q[$];
        logic signed [7:0] q7[$];
        logic signed [7:0] e, e7;
        int since, accepts, budget, d;
        since = 0; accepts = 0;
        @(negedge clk);
        for (int cyc = 0; cyc < 60; cyc++) begin
            d = rand8();
            in_valid = 1'b1; in_data = 8'(d);
            if (out_valid === 1'b1) begin
                e = (q.size() > 0) ? q.pop_front() : 8'sd0;
                e7 = (q7.size() > 0) ? q7.pop_front() : 8'sd0;
                n_cmp++;
                if (out_data !== e) begin n_err++; $display("[TB] FAIL b2b_data: got %0d want %0d", out_data, e); end
                n_cmp++;
                if (out_data7 !== e7) begin n_err++; $display("[TB] FAIL b2b_data_s7: got %0d want %0d", out_data7, e7); end
            end
            if (accepts > 0 && in_ready !== out_valid) begin
                n_err++; $display("[TB] FAIL b2b_coincide: in_ready %b out_valid %b", in_ready, out_valid);
            end
            if (in_ready === 1'b1) begin
                if (accepts > 0) begin
                    n_cmp++;
                    if (since != 10) begin n_err++; $display("[TB] FAIL b2b_spacing: got %0d want 10", since); end
                end
                model_push(d);
                q.push_back(8'(model_y(0)));
                q7.push_back(8'(model_y(7)));
                accepts++;
                since = 0;
            end
            @(negedge clk);
            since++;
        end
        in_valid = 1'b0;
        n_cmp++;
        if (accepts != 6) begin n_err++; $display("[TB] FAIL b2b_accepts: got %0d want 6", accepts); end
        budget = 0;
        while (q.size() > 0 && budget < 30) begin
            if (out_valid === 1'b1) begin
                e = q.pop_front();
                void'(q7.pop_front());
                n_cmp++;
                if (out_data !== e) begin n_err++; $display("[TB] FAIL b2b_drain: got %0d want %0d", out_data, e); end
            end
            @(negedge clk);
            budget++;
        end
        n_cmp++;
        if (q.size() != 0) begin n_err++; $display("[TB] FAIL b2b_timeout: got %0d pending want 0", q.size()); end
    endtask

    task automatic test_reset_mid_mac();
        logic signed [7:0] y, y7;
        int lat; bit tmo, seen;
        @(negedge clk);
        in_data = 8'sd50; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b1) begin n_err++; $display("[TB] FAIL abort_busy: got %b want 1", busy); end
        reset = 1'b1;
        #1;
        n_cmp++; if (out_data !== 8'sd0) begin n_err++; $display("[TB] FAIL abort_out_data: got %0d want 0", out_data); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("[TB] FAIL abort_in_ready: got %b want 1", in_ready); end
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        seen = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        n_cmp++;
        if (seen) begin n_err++; $display("[TB] FAIL abort_no_pulse: got pulse want none"); end
        run_sample(100, 0, 0, 0, y, y7, lat, tmo);
        n_cmp++;
        if (tmo || y !== 8'(model_y(0))) begin n_err++; $display("[TB] FAIL abort_cleared: got %0d want 0", y); end
    endtask

    task automatic test_taps6();
        int d, lat, budget, v;
        logic signed [7:0] e;
        do_reset();
        for (int a = 0; a < 8; a++) begin
            v = (a < 6) ? rand8() : 99;
            @(negedge clk);
            coef_we6 = 1'b1; coef_addr6 = 3'(a); coef_data6 = 8'(v);
            @(negedge clk);
            coef_we6 = 1'b0;
            if (a < 6) mc6[a] = v;
        end
        for (int i = 0; i < 8; i++) begin
            d = rand8();
            @(negedge clk);
            in_data6 = 8'(d); in_valid6 = 1'b1;
            budget = 0;
            while (in_ready6 !== 1'b1 && budget < 40) begin @(negedge clk); budget++; end
            for (int k = 5; k > 0; k--) mx6[k] = mx6[k-1];
            mx6[0] = d;
            @(negedge clk);
            in_valid6 = 1'b0;
            lat = 0;
            while (out_valid6 !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
            e = 8'(model6_y(1));
            n_cmp++;
            if (out_data6 !== e) begin n_err++; $display("[TB] FAIL taps6[%0d]: got %0d want %0d", i, out_data6, e); end
            n_cmp++;
            if (lat != 7) begin n_err++; $display("[TB] FAIL taps6_latency[%0d]: got %0d want 7", i, lat); end
        end
    endtask

    initial begin
        reset = 1'b1;
        in_data = '0; in_valid = 1'b0; coef_we = 1'b0; coef_addr = '0; coef_data = '0;
        in_data6 = '0; in_valid6 = 1'b0; coef_we6 = 1'b0; coef_addr6 = '0; coef_data6 = '0;
        model_clear();
        test_reset();
        test_impulse();
        test_coef_order();
        test_saturation();
        test_coef_write();
        test_random();
        test_back_to_back();
        test_reset_mid_mac();
        test_taps6();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/fir_mac_serial.md
Name: fir_mac_serial

Overview:
Time-multiplexed FIR core: one signed multiplier and one accumulator iterate over TAPS coefficients per input sample. It accepts samples on a valid/ready handshake and holds the tap delay line and coefficient bank internally. It emits one filtered, scaled and saturated sample per input as a one-cycle out_valid pulse. It sits directly upstream of the team's generic output register: out_data drives that register's datain and out_valid drives its enable.

Parameters:
WIDTH_DATA, 8, sample width and output width (signed two's complement)
WIDTH_COEF, 8, coefficient width (signed)
TAPS, 8, number of taps (>=2)
SHIFT, 0, arithmetic right shift applied to the accumulator before saturation
WIDTH_ACC (derived, not overridable), WIDTH_DATA+WIDTH_COEF+clog2(TAPS), accumulator width

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
in_data  input  WIDTH_DATA  new sample (signed)
in_valid  input  1  in_data valid
in_ready  output  1  high only in IDLE; a sample is taken on a rising edge where in_valid&in_ready
coef_we  input  1  coefficient write strobe
coef_addr  input  clog2(TAPS)  coefficient index
coef_data  input  WIDTH_COEF  coefficient value (signed)
busy  output  1  high in MAC or DONE
out_data  output  WIDTH_DATA  filtered sample (signed), registered
out_valid  output  1  one-cycle pulse; out_data is valid in that cycle

Behaviour:
- Reset (async, active-high): state=IDLE; delay line x[0..TAPS-1]=0; coefficient bank c[0..TAPS-1]=0; acc=0; idx=0; out_data=0; out_valid=0; in_ready=1; busy=0.
- Reset mid-operation: the computation is aborted with no output. Delay line and coefficients are also cleared.
- States: IDLE, MAC, DONE.
- IDLE:
  - On an edge with in_valid=1: x[k]<=x[k-1] for k=1..TAPS-1; x[0]<=in_data; acc<=0; idx<=0; next state MAC.
  - Otherwise stay in IDLE; the delay line holds.
- MAC: each edge does acc<=acc+x[idx]*c[idx] (full-precision signed product, sign-extended to WIDTH_ACC) and idx<=idx+1. On the edge where idx==TAPS-1, go to DONE instead of incrementing.
- DONE (exactly one cycle):
  - On the leaving edge: out_data<=sat(acc>>>SHIFT); out_valid<=1; next state IDLE.
  - sat clamps to [-2^(WIDTH_DATA-1), 2^(WIDTH_DATA-1)-1]. Rounding is truncation toward minus infinity (arithmetic shift).
- out_valid is registered and high for exactly one cycle, the first IDLE cycle after DONE. out_data holds its value until the next DONE.
- Latency: sample accepted at edge E0; out_valid high in the cycle after edge E(TAPS+1).
- Throughput: one sample per TAPS+2 cycles. A new sample may be accepted in the same cycle out_valid is high.
- Output is y[n]=sum over k of c[k]*x[n-k]; c[0] multiplies the newest sample.
- WIDTH_ACC guarantees no accumulator overflow for any inputs.
- Coefficient writes:
  - Applied on the edge only when state==IDLE and coef_addr<TAPS.
  - Ignored when busy or when the address is out of range.
  - A coefficient write and a sample accept in the same IDLE edge are both applied. The new sample uses the updated coefficient.
- in_valid while busy: ignored (in_ready=0). The upstream block must hold the sample.

Test Plan:
1. Reset with TAPS=8, SHIFT=0, coefficients all written to 1. Feed impulse 10 then seven 0s -> eight out_valid pulses, all out_data=10. A ninth sample 0 -> out_data=0.
2. Coefficients c[k]=k+1, SHIFT=0. Feed samples 1,0,0 -> outputs 1,2,3 (each coefficient read in order). Accept-to-out_valid spacing is exactly TAPS+1=9 edges.
3. Saturation: coefficients all 127, eight samples of 127, SHIFT=0 -> positive saturation, out_data=127. Coefficients all 127, samples -128 -> out_data=-128. SHIFT=7 with the positive stimulus: acc=8*127*127=129032, 129032>>>7=1008 -> saturates to 127.
4. Handshake: hold in_valid=1 continuously -> in_ready high one cycle in every 10. Exactly one sample is accepted per 10 cycles, and out_valid coincides with the next in_ready.
5. Coefficient write while busy (addr 0, value 5) is ignored and the result is unchanged. The same write issued in IDLE is applied. A write with coef_addr >= TAPS (only possible when TAPS is not a power of two, e.g. TAPS=6, addr 7) is ignored.
6. Assert reset during MAC (idx=3) -> out_valid never pulses, out_data=0, in_ready=1 immediately after reset. Delay line and coefficient bank read back as zero: the next impulse gives output 0.
